// File: rtl/phase_pkg.sv
// Shared constants for the phase-detection back end: widths, octant flag
// bit positions, error bit positions and turn-fraction helpers.
package phase_pkg;

  localparam int PHASE_W_DEF = 12;

  localparam int FLAG_SWAP    = 2;
  localparam int FLAG_IMAGNEG = 1;
  localparam int FLAG_REALPOS = 0;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  function automatic int quarter_turn(input int phase_w);
    return 1 << (phase_w - 2);
  endfunction

  function automatic int eighth_turn(input int phase_w);
    return 1 << (phase_w - 3);
  endfunction

endpackage

// File: rtl/angle_reconstruct_if.sv
// Flag/arctangent input bundle and phase/error outputs of angle_reconstruct.
interface angle_reconstruct_if #(
  parameter int PHASE_W = 12
);
  logic               flag_val_i;
  logic [2:0]         case_flag_i;
  logic               zero_i;
  logic               atan_val_i;
  logic [PHASE_W-3:0] atan_i;
  logic [PHASE_W-1:0] phase_o;
  logic               val_o;
  logic [1:0]         err_o;

  modport master (
    output flag_val_i, case_flag_i, zero_i, atan_val_i, atan_i,
    input  phase_o, val_o, err_o
  );

  modport slave (
    input  flag_val_i, case_flag_i, zero_i, atan_val_i, atan_i,
    output phase_o, val_o, err_o
  );
endinterface

// File: rtl/flag_fifo.sv
// Small in-order FIFO with a registered read port; reports full/empty and
// single-cycle overflow/underflow pulses for rejected pushes and pops.
module flag_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         pop_valid,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  // A pop frees the slot a push into a full FIFO needs in the same cycle.
  assign push_ok   = push && (!full || pop_ok);
  assign overflow  = push && !push_ok;
  assign underflow = pop && empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
    if (pop_ok)  pop_data    <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/angle_reconstruct.sv
// Re-pairs buffered octant flags with first-octant arctangent results and
// unfolds them into a full-circle phase word through a 2-stage pipeline.
module angle_reconstruct
  import phase_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DEPTH   = 8
) (
  input logic                clk,
  input logic                rst,
  angle_reconstruct_if.slave bus
);
  localparam int AW = PHASE_W - 2;
  localparam int XW = PHASE_W + 1;
  localparam logic [XW-1:0] QUARTER = XW'(quarter_turn(PHASE_W));
  localparam logic [XW-1:0] HALF    = XW'(2 * quarter_turn(PHASE_W));
  localparam logic [XW-1:0] FULL    = XW'(4 * quarter_turn(PHASE_W));
  localparam logic [AW-1:0] EIGHTH  = AW'(eighth_turn(PHASE_W));

  function automatic logic [AW-1:0] clamp_atan(input logic [AW-1:0] a);
    return (a > EIGHTH) ? EIGHTH : a;
  endfunction

  // Reflect the first-octant angle through the swap, real and imag mirrors;
  // the final truncation folds a full turn back to 0.
  function automatic logic [PHASE_W-1:0] unfold(input logic [2:0]    flag,
                                                input logic [AW-1:0] a);
    logic [XW-1:0] a0, a1, a2, ph;
    a0 = XW'(a);
    a1 = flag[FLAG_SWAP]    ? QUARTER - a0 : a0;
    a2 = flag[FLAG_REALPOS] ? a1 : HALF - a1;
    ph = flag[FLAG_IMAGNEG] ? FULL - a2 : a2;
    return ph[PHASE_W-1:0];
  endfunction

  logic [3:0]         head_p1;
  logic               vld_p1;
  logic [AW-1:0]      atan_p1;
  logic               ovf;
  logic               udf;
  logic               fifo_full;
  logic               fifo_empty;
  logic               unused_status;
  logic [PHASE_W-1:0] phase_p2;
  logic               vld_p2;
  logic [1:0]         err;

  assign unused_status = &{1'b0, fifo_full, fifo_empty};

  flag_fifo #(
    .W     (4),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.flag_val_i),
    .push_data ({bus.zero_i, bus.case_flag_i}),
    .pop       (bus.atan_val_i),
    .pop_data  (head_p1),
    .pop_valid (vld_p1),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (ovf),
    .underflow (udf)
  );

  // Stage 1: clamped arctangent registered alongside the popped FIFO head.
  always_ff @(posedge clk) begin
    if (bus.atan_val_i) atan_p1 <= clamp_atan(bus.atan_i);
  end

  // Stage 2: octant unfold, zero override and sticky error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p2 <= '0;
      vld_p2   <= 1'b0;
      err      <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) phase_p2 <= head_p1[3] ? '0 : unfold(head_p1[2:0], atan_p1);
      if (ovf) err[ERR_OVF] <= 1'b1;
      if (udf) err[ERR_UDF] <= 1'b1;
    end
  end

  assign bus.phase_o = phase_p2;
  assign bus.val_o   = vld_p2;
  assign bus.err_o   = err;

endmodule

// File: tb/tb_angle_reconstruct.sv
// Scoreboard bench for angle_reconstruct: directed octant/boundary cases,
// FIFO error scenarios, reset mid-stream and randomized traffic.
module tb_angle_reconstruct;
  localparam int PHASE_W = 12;
  localparam int DEPTH   = 8;

  typedef struct { bit [2:0] f; bit z; } flag_t;
  typedef struct { int ph; int cyc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  flag_t    mq[$];
  exp_t     expq[$];
  bit [1:0] merr = 2'b00;

  angle_reconstruct_if #(.PHASE_W(PHASE_W)) bus();

  angle_reconstruct #(.PHASE_W(PHASE_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Geometric view: pick the quadrant from the sign flags, then place the
  // octant angle measured from the nearer axis according to the swap flag.
  function automatic int ref_phase(input bit [2:0] f, input bit z, input int atan);
    int a, ph;
    bit swap, imagneg, realpos;
    if (z) return 0;
    a = (atan > 512) ? 512 : atan;
    swap = f[2]; imagneg = f[1]; realpos = f[0];
    if (realpos && !imagneg)      ph = swap ? 1024 - a : a;
    else if (!realpos && !imagneg) ph = swap ? 1024 + a : 2048 - a;
    else if (!realpos && imagneg)  ph = swap ? 3072 - a : 2048 + a;
    else                           ph = swap ? 3072 + a : 4096 - a;
    return ph % 4096;
  endfunction

  task automatic clear_inputs();
    bus.flag_val_i  = 1'b0;
    bus.case_flag_i = 3'b000;
    bus.zero_i      = 1'b0;
    bus.atan_val_i  = 1'b0;
    bus.atan_i      = '0;
  endtask

  task automatic step(input bit push, input bit [2:0] f, input bit z,
                      input bit pop, input int atan);
    bit    pop_ok, push_ok;
    flag_t e;
    bus.flag_val_i  = push;
    bus.case_flag_i = f;
    bus.zero_i      = z;
    bus.atan_val_i  = pop;
    bus.atan_i      = 10'(atan);
    pop_ok  = pop && (mq.size() > 0);
    push_ok = push && ((mq.size() < DEPTH) || pop_ok);
    if (pop && !pop_ok)   merr[1] = 1'b1;
    if (push && !push_ok) merr[0] = 1'b1;
    if (pop_ok) begin
      e = mq.pop_front();
      expq.push_back('{ph: ref_phase(e.f, e.z, atan), cyc: cyc + 2});
    end
    if (push_ok) mq.push_back('{f: f, z: z});
    @(posedge clk);
    #1;
    chk("err_o", int'(bus.err_o), int'(merr));
    clear_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic pair(input bit [2:0] f, input bit z, input int atan);
    step(1'b1, f, z, 1'b0, 0);
    idle(2);
    step(1'b0, 3'b000, 1'b0, 1'b1, atan);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    mq.delete();
    expq.delete();
    merr = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_phase", int'(bus.phase_o), 0);
    chk("rst_val", int'(bus.val_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.val_o) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_val: got phase %0d expected no output", bus.phase_o);
      end else begin
        e = expq.pop_front();
        chk("phase", int'(bus.phase_o), e.ph);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] tbl_f [5] = '{3'b001, 3'b101, 3'b000, 3'b011, 3'b110};
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 5; i++) pair(tbl_f[i], 1'b0, 100);
    pair(3'b011, 1'b0, 0);
    pair(3'b001, 1'b0, 700);
    pair(3'($urandom_range(0, 7)), 1'b1, $urandom_range(0, 1023));
    pair(3'b110, 1'b1, 300);

    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b0, 1'b1, $urandom_range(0, 600));
    idle(3);

    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 3'(i + 3), 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b0, 1'b1, 50 + 30 * i);
    idle(3);

    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 3'(7 - i), 1'b0, 1'b0, 0);
    step(1'b1, 3'b010, 1'b0, 1'b1, 222);
    for (int i = 0; i < 8; i++) step(1'b0, 3'b000, 1'b0, 1'b1, 400 - 20 * i);
    idle(3);

    do_reset();
    step(1'b0, 3'b000, 1'b0, 1'b1, 123);
    idle(2);
    pair(3'b101, 1'b0, 77);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0, 1'b0, 0);
    step(1'b0, 3'b000, 1'b0, 1'b1, 200);
    do_reset();
    step(1'b0, 3'b000, 1'b0, 1'b1, 250);
    idle(3);

    do_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 50), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) < 45),
           $urandom_range(0, 1023));
    idle(4);
    chk("pending_results", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
